zero_run_detector: RTL

Parametrised multi-channel zero-run (sleep) detector for the MSDAP input path. It counts consecutive all-zero valid samples per channel with saturating counters and raises per-channel and joint zero flags after ZERO_RUN samples. A two-state sleep FSM issues one-cycle sleep-entry and wake pulses to the controller. It generalises the fixed two-channel, 800-sample detector to N channels, a parametrised threshold, runtime channel masking and explicit entry/exit events.

---
 rtl/zero_run_detector_pkg.sv | 20 ++
 rtl/zero_run_detector_if.sv | 49 ++++
 rtl/zero_run_detector_counter.sv | 57 +++++
 rtl/zero_run_detector.sv | 125 ++++++++++++
 4 files changed

// File: rtl/zero_run_detector_pkg.sv
// Shared types and default constants for the MSDAP zero-run (sleep) detector.
package msdap_zero_pkg;

    // Sleep FSM encoding: ACTIVE while audio is present, SLEEP once every
    // enabled channel has been silent for a full run.
    typedef enum logic {
        ACTIVE = 1'b0,
        SLEEP  = 1'b1
    } zr_state_e;

    localparam int NUM_CH_DEF   = 2;
    localparam int DATA_W_DEF   = 16;
    localparam int ZERO_RUN_DEF = 800;

    // Counter width able to hold the saturation value ZERO_RUN itself.
    function automatic int cnt_width(input int zero_run);
        return $clog2(zero_run + 1);
    endfunction

endpackage

// File: rtl/zero_run_detector_if.sv
// Sample/status bundle between the MSDAP input path and the zero-run detector.
// The counter width is derived from ZERO_RUN so both ends always agree on it.
interface zero_run_detector_if
    import msdap_zero_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ZERO_RUN = ZERO_RUN_DEF
);
    localparam int CNT_W = cnt_width(ZERO_RUN);

    logic                     clear;
    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        chan_en;

    logic [NUM_CH-1:0]        ch_zero;
    logic                     all_zeros;
    logic                     sleep_enter;
    logic                     wake;
    logic [NUM_CH*CNT_W-1:0]  run_count;

    // Sample source / controller side.
    modport master (
        output clear,
        output sample_valid,
        output data,
        output chan_en,
        input  ch_zero,
        input  all_zeros,
        input  sleep_enter,
        input  wake,
        input  run_count
    );

    // Detector side.
    modport slave (
        input  clear,
        input  sample_valid,
        input  data,
        input  chan_en,
        output ch_zero,
        output all_zeros,
        output sleep_enter,
        output wake,
        output run_count
    );

endinterface

// File: rtl/zero_run_detector_counter.sv
// One channel's saturating zero-run counter and its registered ch_zero flag.
// ch_zero_nxt exposes the next-state flag so the top-level FSM can move on the
// same edge that completes the run.
module zero_run_counter
    import msdap_zero_pkg::*;
#(
    parameter  int ZERO_RUN = ZERO_RUN_DEF,
    localparam int CNT_W    = cnt_width(ZERO_RUN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic             is_zero,
    output logic [CNT_W-1:0] count,
    output logic             ch_zero,
    output logic             ch_zero_nxt
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(ZERO_RUN);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;
    logic             ch_zero_d;
    logic             ch_zero_q;

    // Next count: clear wins, otherwise only valid samples advance or reset it.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (valid) begin
            if (!is_zero) begin
                count_d = '0;
            end else if (count_q != SAT) begin
                count_d = count_q + CNT_W'(1);
            end
        end
        ch_zero_d = (count_d == SAT);
    end

    // Count and flag are registered together so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            ch_zero_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            ch_zero_q <= ch_zero_d;
        end
    end

    assign count       = count_q;
    assign ch_zero     = ch_zero_q;
    assign ch_zero_nxt = ch_zero_d;

endmodule

// File: rtl/zero_run_detector.sv
// Multi-channel zero-run detector: per-channel saturating counters, a joint
// "all enabled channels silent" decision and a two-state sleep FSM that emits
// one-cycle sleep-entry and wake pulses.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   ACTIVE | audio present (or no channel enabled); all_zeros low
//   SLEEP  | every enabled channel silent for ZERO_RUN samples; all_zeros high
//
// The FSM decides from the counters' next-state flags, so all_zeros and
// sleep_enter rise on the same edge that clocks the completing zero sample.
module zero_run_detector
    import msdap_zero_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ZERO_RUN = ZERO_RUN_DEF
) (
    input logic               clk,
    input logic               rst_n,
    zero_run_detector_if.slave bus
);

    localparam int CNT_W = cnt_width(ZERO_RUN);

    logic [NUM_CH-1:0]       nonzero;
    logic [NUM_CH-1:0]       zero_nxt;
    logic [NUM_CH-1:0]       ch_zero_all;
    logic [NUM_CH*CNT_W-1:0] count_all;

    logic                    joint_d;
    logic                    wake_cause;

    zr_state_e               state_d;
    zr_state_e               state_q;
    logic                    sleep_enter_d;
    logic                    sleep_enter_q;
    logic                    wake_d;
    logic                    wake_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign nonzero[i] = |bus.data[i*DATA_W +: DATA_W];

        zero_run_counter #(
            .ZERO_RUN (ZERO_RUN)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear       (bus.clear),
            .valid       (bus.sample_valid),
            .is_zero     (~nonzero[i]),
            .count       (count_all[i*CNT_W +: CNT_W]),
            .ch_zero     (ch_zero_all[i]),
            .ch_zero_nxt (zero_nxt[i])
        );
    end

    // Joint silence over enabled channels; an empty mask never counts as silent.
    // Disabled channels keep counting but cannot block or trigger a decision.
    always_comb begin
        joint_d    = (|bus.chan_en) && ((zero_nxt & bus.chan_en) == bus.chan_en);
        wake_cause = bus.sample_valid && (|(nonzero & bus.chan_en));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear forces ACTIVE; SLEEP is left on real data or when the
    // mask changes such that the joint condition no longer holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE: begin
                if (!bus.clear && joint_d) begin
                    state_d = SLEEP;
                end
            end
            SLEEP: begin
                if (bus.clear || wake_cause || !joint_d) begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    // Transition pulses; wake only for data-caused exits, never for clear or
    // a mask change.
    always_comb begin
        sleep_enter_d = 1'b0;
        wake_d        = 1'b0;
        if ((state_q == ACTIVE) && (state_d == SLEEP)) begin
            sleep_enter_d = 1'b1;
        end
        if ((state_q == SLEEP) && !bus.clear && wake_cause) begin
            wake_d = 1'b1;
        end
    end

    // Pulse registers, so every output leaves the block from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sleep_enter_q <= 1'b0;
            wake_q        <= 1'b0;
        end else begin
            sleep_enter_q <= sleep_enter_d;
            wake_q        <= wake_d;
        end
    end

    assign bus.ch_zero     = ch_zero_all;
    assign bus.run_count   = count_all;
    assign bus.all_zeros   = (state_q == SLEEP);
    assign bus.sleep_enter = sleep_enter_q;
    assign bus.wake        = wake_q;

endmodule
